// File: rtl/avl_resp_pkg.sv
// avl_resp_pkg: shared state encoding and default parameters for the Avalon DDR3 responder model
package avl_resp_pkg;
   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_e;
   localparam int DEF_ADDR_W       = 10;
   localparam int DEF_DATA_W       = 128;
   localparam int DEF_INIT_CYCLES  = 64;
   localparam int DEF_READ_LATENCY = 4;
   localparam int DEF_STALL_PERIOD = 0;
   localparam int AVL_ADDR_W       = 26;
endpackage

// File: rtl/rd_latency_pipe.sv
// rd_latency_pipe: fixed-depth read return pipeline; data stages load only behind a valid so the last word holds
module rd_latency_pipe #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vin,
   input  logic [DATA_W-1:0] din,
   output logic              vout,
   output logic [DATA_W-1:0] dout
);
   logic [DEPTH-1:0]  v;
   logic [DATA_W-1:0] d [DEPTH];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v <= '0;
      else begin
         v[0] <= vin;
         for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
      end
   always_ff @(posedge clk) begin
      if (vin) d[0] <= din;
      for (int i = 1; i < DEPTH; i++) if (v[i-1]) d[i] <= d[i-1];
   end
   assign vout = v[DEPTH-1];
   assign dout = d[DEPTH-1];
endmodule

// File: rtl/avl_ddr3_responder.sv
// avl_ddr3_responder: behavioural Avalon-MM DDR3 controller stand-in with init delay, fixed read latency and optional stalls
module avl_ddr3_responder
   import avl_resp_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
   parameter int READ_LATENCY = DEF_READ_LATENCY,
   parameter int STALL_PERIOD = DEF_STALL_PERIOD
) (
   input  logic                  iCLK,
   input  logic                  iRST_n,
   input  logic                  avl_burstbegin,
   input  logic [AVL_ADDR_W-1:0] avl_address,
   input  logic [DATA_W-1:0]     avl_writedata,
   input  logic                  avl_write,
   input  logic                  avl_read,
   output logic                  local_init_done,
   output logic                  avl_wait_request_n,
   output logic [DATA_W-1:0]     avl_readdata,
   output logic                  avl_readdatavalid,
   output logic                  err_both,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
);
   localparam logic [31:0] IC_LAST = 32'(INIT_CYCLES - 1);
   localparam logic [31:0] SP_LAST = 32'(STALL_PERIOD - 1);
   state_e            state;
   logic [31:0]       icnt;
   logic [31:0]       scnt;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] a;
   logic              acc, acc_wr, acc_rd, stall_hit, seen, pv;
   logic [DATA_W-1:0] pd;
   logic              unused;
   assign unused    = &{1'b0, avl_burstbegin, avl_address[AVL_ADDR_W-1:ADDR_W]};
   assign a         = avl_address[ADDR_W-1:0];
   assign acc       = (avl_read | avl_write) & avl_wait_request_n;
   assign acc_wr    = acc & avl_write;
   assign acc_rd    = acc & avl_read & ~avl_write;
   assign stall_hit = (STALL_PERIOD > 0) && acc && scnt == SP_LAST;
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         state              <= INIT;
         icnt               <= '0;
         scnt               <= '0;
         local_init_done    <= 1'b0;
         avl_wait_request_n <= 1'b0;
         err_both           <= 1'b0;
         rd_count           <= '0;
         wr_count           <= '0;
         seen               <= 1'b0;
      end else begin
         seen <= seen | pv;
         if (state == INIT) begin
            icnt <= icnt + 32'd1;
            if (icnt == IC_LAST) begin
               state              <= READY;
               local_init_done    <= 1'b1;
               avl_wait_request_n <= 1'b1;
            end
         end else begin
            avl_wait_request_n <= ~stall_hit;
            if (acc) scnt <= stall_hit ? '0 : scnt + 32'd1;
            if (acc & avl_read & avl_write) err_both <= 1'b1;
            if (acc_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (acc_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         end
      end
   always_ff @(posedge iCLK)
      if (acc_wr) mem[a] <= avl_writedata;
   rd_latency_pipe #(.DEPTH(READ_LATENCY), .DATA_W(DATA_W)) u_pipe (
      .clk  (iCLK),
      .rst_n(iRST_n),
      .vin  (acc_rd),
      .din  (mem[a]),
      .vout (pv),
      .dout (pd)
   );
   // until the first return after reset the visible data is zero; afterwards the last stage holds
   assign avl_readdatavalid = pv;
   assign avl_readdata      = (seen | pv) ? pd : '0;
endmodule
